// File: rtl/spi_target_8bit_if.sv
// rtl/spi_target_8bit_if.sv - signal bundle between an SPI target and its host logic
//
// Groups the SPI pad signals and the host-side byte handshake.
//   spi_sclk, spi_cs_n, spi_mosi : serial inputs from the initiator
//   spi_miso, spi_miso_oe        : serial output and its pad enable
//   tx_data, tx_load, tx_ready   : host -> target byte to return
//   rx_data, rx_valid            : target -> host received byte
//   busy, err_underrun, err_clr  : status and error clear
// Modport slave is the target block; modport master is the side that drives it.
interface spi_target_8bit_if;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       err_underrun;
   logic       err_clr;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load, err_clr,
      output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, err_underrun
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load, err_clr,
      input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, err_underrun
   );
endinterface

// File: rtl/spi_target_8bit.sv
// rtl/spi_target_8bit.sv - SPI mode-0 target, one 8-bit transfer per chip-select frame
//
// Ports:
//   clk   : system clock, all logic on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_target_8bit_if.slave (SPI pads, tx holding-register load,
//           rx byte/valid, busy, sticky underrun error and its clear)
// Parameter:
//   SYNC_STAGES : synchronizer depth on each SPI input (2..3)
// Build option:
//   SPI_TARGET_LSB_FIRST_EN : when defined both directions shift LSB first,
//                             otherwise MSB first.
module spi_target_8bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_target_8bit_if.slave      bus
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_prev;
   logic                   cs_prev;
   logic [SYNC_STAGES:0]   settle;
   logic                   armed;

   logic [0:0] state;
   logic [2:0] bit_cnt;
   logic [7:0] tx_shift;
   logic [7:0] rx_shift;
   logic [7:0] hold_reg;
   logic       hold_full;
   logic       rx_done;
   logic [7:0] rx_data_r;
   logic       rx_valid_r;
   logic       err_r;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic frame_start;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_rise   = cs_s & ~cs_prev;
   assign cs_fall   = ~cs_s & cs_prev;

   // The cs_n chain resets to "deselected"; if the pad is already low when
   // reset is released that would look like a falling edge. Frames are only
   // accepted once cs_n has been seen high after the chain has flushed.
   assign frame_start = (state == ST_IDLE) & cs_fall & armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
         settle    <= '0;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
         settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
         if (settle[SYNC_STAGES] && cs_s && cs_prev)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         tx_shift   <= 8'h00;
         rx_shift   <= 8'h00;
         hold_reg   <= 8'h00;
         hold_full  <= 1'b0;
         rx_done    <= 1'b0;
         rx_data_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         // rx_data is published one cycle after the 8th sample lands.
         rx_done    <= 1'b0;
         rx_valid_r <= 1'b0;
         if (rx_done) begin
            rx_data_r  <= rx_shift;
            rx_valid_r <= 1'b1;
         end

         // A load coinciding with frame start keeps the register full for the
         // next frame; the current frame has already taken the old contents.
         if (bus.tx_load) begin
            hold_reg  <= bus.tx_data;
            hold_full <= 1'b1;
         end else if (frame_start) begin
            hold_full <= 1'b0;
         end

         // Setting wins over clearing.
         if (frame_start && !hold_full)
            err_r <= 1'b1;
         else if (bus.err_clr)
            err_r <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  state    <= ST_ACTIVE;
                  bit_cnt  <= 3'd0;
                  tx_shift <= hold_full ? hold_reg : 8'h00;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state   <= ST_IDLE;
                  bit_cnt <= 3'd0;
               end else if (sclk_rise) begin
`ifdef SPI_TARGET_LSB_FIRST_EN
                  rx_shift <= {mosi_s, rx_shift[7:1]};
`else
                  rx_shift <= {rx_shift[6:0], mosi_s};
`endif
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state   <= ST_IDLE;
                     rx_done <= 1'b1;
                  end
               end else if (sclk_fall) begin
`ifdef SPI_TARGET_LSB_FIRST_EN
                  tx_shift <= {1'b0, tx_shift[7:1]};
`else
                  tx_shift <= {tx_shift[6:0], 1'b0};
`endif
               end
            end
            default: begin
               state   <= ST_IDLE;
               bit_cnt <= 3'd0;
            end
         endcase
      end
   end

`ifdef SPI_TARGET_LSB_FIRST_EN
   assign bus.spi_miso = (state == ST_ACTIVE) & tx_shift[0];
`else
   assign bus.spi_miso = (state == ST_ACTIVE) & tx_shift[7];
`endif
   assign bus.spi_miso_oe  = (state == ST_ACTIVE);
   assign bus.busy         = (state == ST_ACTIVE);
   assign bus.tx_ready     = ~hold_full;
   assign bus.rx_data      = rx_data_r;
   assign bus.rx_valid     = rx_valid_r;
   assign bus.err_underrun = err_r;

endmodule
